// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: latency codes, forwarding selects
// and the parameter sanity rule checked at elaboration.
package hazard_scoreboard_pkg;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int FWD_RF   = 0;

  // Stage indices must fit in the latency/select field, and at least EX plus one
  // later stage must exist for forwarding to be meaningful.
  function automatic bit cfg_ok(input int depth, input int lat_w);
    return (depth >= 2) && ((1 << lat_w) > depth);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// One operand's view of the scoreboard: finds the youngest in-flight producer
// of rs and turns it into a forwarding select or a hazard.
module hazard_scoreboard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int LAT_W  = 2
) (
  input  logic                          use_rs,
  input  logic [REG_AW-1:0]             rs,
  input  logic [DEPTH-1:0]              ent_valid,
  input  logic [DEPTH-1:0][REG_AW-1:0]  ent_rd,
  input  logic [DEPTH-1:0][LAT_W-1:0]   ent_lat,
  output logic [LAT_W-1:0]              sel,
  output logic                          hazard
);

  logic             hit;
  logic [LAT_W-1:0] hit_stage;
  logic [LAT_W-1:0] hit_lat;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    hit       = 1'b0;
    hit_stage = '0;
    hit_lat   = '0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_rs && (rs != '0) && ent_valid[k] && (ent_rd[k] == rs)) begin
        hit       = 1'b1;
        hit_stage = LAT_W'(k + 1);
        hit_lat   = ent_lat[k];
      end
    end
    hazard = hit && (hit_stage < hit_lat);
    sel    = (hit && !hazard) ? hit_stage : LAT_W'(FWD_RF);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of the DEPTH instructions issued after decode and
// produces operand forwarding selects, a load-use stall and a stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int LAT_W  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_rd,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              ext_stall,
  input  logic [DEPTH-1:0]  flush_mask,
  input  logic              flush_id,
  output logic [LAT_W-1:0]  fwd_sel_1,
  output logic [LAT_W-1:0]  fwd_sel_2,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  if (!cfg_ok(DEPTH, LAT_W)) begin : g_bad_cfg
    $error("hazard_scoreboard: need DEPTH>=2 and 2**LAT_W > DEPTH");
  end

  // Index k-1 holds the instruction now in stage k.
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
  logic [DEPTH-1:0][LAT_W-1:0]  ent_lat;

  logic hazard_1;
  logic hazard_2;
  logic issue;

  hazard_scoreboard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LAT_W(LAT_W)) u_match_1 (
    .use_rs    (id_use_rs1),
    .rs        (id_rs1),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd),
    .ent_lat   (ent_lat),
    .sel       (fwd_sel_1),
    .hazard    (hazard_1)
  );

  hazard_scoreboard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LAT_W(LAT_W)) u_match_2 (
    .use_rs    (id_use_rs2),
    .rs        (id_rs2),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd),
    .ent_lat   (ent_lat),
    .sel       (fwd_sel_2),
    .hazard    (hazard_2)
  );

  assign stall = id_valid && !flush_id && (hazard_1 || hazard_2);
  assign issue = id_valid && id_wr_rd && !stall && !flush_id;

  // Flush addresses post-shift positions, so it is applied after the shift and
  // also kills a new issue landing in stage 1.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
    end else if (!ext_stall) begin
      ent_valid <= {ent_valid[DEPTH-2:0], issue} & ~flush_mask;
    end else begin
      ent_valid <= ent_valid & ~flush_mask;
    end
  end

  // NOTE: payload fields are qualified by ent_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!ext_stall) begin
      ent_rd  <= {ent_rd[DEPTH-2:0], id_rd};
      ent_lat <= {ent_lat[DEPTH-2:0], id_lat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios followed
// by random traffic, all compared against an age-ordered reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int DEPTH  = 3;
  localparam int REG_AW = 5;
  localparam int LAT_W  = 2;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_wr_rd;
  logic [LAT_W-1:0]  id_lat;
  logic              ext_stall;
  logic [DEPTH-1:0]  flush_mask;
  logic              flush_id;
  logic [LAT_W-1:0]  fwd_sel_1, fwd_sel_2;
  logic              stall;
  logic [CNT_W-1:0]  stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_wr_rd     (id_wr_rd),
    .id_lat       (id_lat),
    .ext_stall    (ext_stall),
    .flush_mask   (flush_mask),
    .flush_id     (flush_id),
    .fwd_sel_1    (fwd_sel_1),
    .fwd_sel_2    (fwd_sel_2),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m[a] is the instruction issued a unfrozen cycles ago.
  typedef struct {
    bit v;
    int rd;
    int lat;
  } m_ent_t;

  m_ent_t m [DEPTH+1];
  longint m_cnt;
  longint cnt_max = (longint'(1) << CNT_W) - 1;

  logic [LAT_W-1:0] obs_sel1, obs_sel2;
  logic             obs_stall;
  logic [CNT_W-1:0] obs_cnt;

  function automatic void m_operand(input bit use_rs, input int rs, output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (!use_rs || rs == 0) return;
    for (int a = 1; a <= DEPTH; a++) begin
      if (m[a].v && m[a].rd == rs) begin
        if (a >= m[a].lat) sel = a;
        else               haz = 1'b1;
        return;
      end
    end
  endfunction

  // One cycle: compare combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int s1, s2;
    bit h1, h2, es;
    @(negedge clk);
    m_operand(id_use_rs1, int'(id_rs1), s1, h1);
    m_operand(id_use_rs2, int'(id_rs2), s2, h2);
    es = id_valid && !flush_id && (h1 || h2);
    obs_sel1  = fwd_sel_1;
    obs_sel2  = fwd_sel_2;
    obs_stall = stall;
    obs_cnt   = stall_cycles;
    if (!rst) begin
      check("stall", stall, es);
      if (!es) begin
        check("fwd_sel_1", fwd_sel_1, s1);
        check("fwd_sel_2", fwd_sel_2, s2);
      end
      check("stall_cycles", stall_cycles, m_cnt);
    end
    @(posedge clk);
    if (rst) begin
      for (int a = 1; a <= DEPTH; a++) m[a].v = 1'b0;
      m_cnt = 0;
    end else begin
      if (es && m_cnt != cnt_max) m_cnt++;
      if (!ext_stall) begin
        for (int a = DEPTH; a >= 2; a--) m[a] = m[a-1];
        m[1].v   = id_valid && id_wr_rd && !es && !flush_id;
        m[1].rd  = int'(id_rd);
        m[1].lat = int'(id_lat);
      end
      for (int a = 1; a <= DEPTH; a++) if (flush_mask[a-1]) m[a].v = 1'b0;
    end
    #1;
  endtask

  task automatic op(input bit v, input int rd, input bit wr, input int lat,
                    input int rs1, input bit u1, input int rs2, input bit u2);
    id_valid   = v;
    id_rd      = REG_AW'(rd);
    id_wr_rd   = wr;
    id_lat     = LAT_W'(lat);
    id_rs1     = REG_AW'(rs1);
    id_use_rs1 = u1;
    id_rs2     = REG_AW'(rs2);
    id_use_rs2 = u2;
    ext_stall  = 1'b0;
    flush_mask = '0;
    flush_id   = 1'b0;
  endtask

  task automatic nop();
    op(0, 0, 0, LAT_ALU, 0, 0, 0, 0);
  endtask

  initial begin
    for (int a = 1; a <= DEPTH; a++) m[a] = '{v: 1'b0, rd: 0, lat: 0};
    m_cnt = 0;
    rst = 1'b1;
    nop();
    step();
    step();
    rst = 1'b0;

    // Reset state
    step();
    check("rst_stall", obs_stall, 0);
    check("rst_sel1", obs_sel1, FWD_RF);
    check("rst_cnt", obs_cnt, 0);

    // ALU back-to-back
    op(1, 5, 1, LAT_ALU, 0, 0, 0, 0); step();
    op(1, 6, 1, LAT_ALU, 5, 1, 5, 1); step();
    check("alu_sel1", obs_sel1, 1);
    check("alu_sel2", obs_sel2, 1);
    check("alu_stall", obs_stall, 0);

    // Load-use: one bubble, then forward from stage 2
    op(1, 7, 1, LAT_LOAD, 0, 0, 0, 0); step();
    op(1, 8, 1, LAT_ALU, 7, 1, 1, 1); step();
    check("lu_stall", obs_stall, 1);
    step();
    check("lu_stall_after", obs_stall, 0);
    check("lu_sel1", obs_sel1, 2);
    check("lu_sel2", obs_sel2, 0);
    check("lu_cnt", obs_cnt, 1);

    // Youngest producer wins; x0 never forwarded
    op(1, 3, 1, LAT_ALU, 0, 0, 0, 0); step();
    op(1, 3, 1, LAT_ALU, 0, 0, 0, 0); step();
    op(1, 4, 1, LAT_ALU, 3, 1, 0, 1); step();
    check("yw_sel1", obs_sel1, 1);
    check("yw_sel2", obs_sel2, 0);

    // Distance 3, then retired
    op(1, 9, 1, LAT_ALU, 0, 0, 0, 0); step();
    op(1, 10, 1, LAT_ALU, 1, 1, 2, 1); step();
    op(1, 11, 1, LAT_ALU, 1, 1, 2, 1); step();
    op(1, 12, 1, LAT_ALU, 9, 1, 0, 0); step();
    check("d3_sel1", obs_sel1, 3);
    op(1, 13, 1, LAT_ALU, 9, 1, 0, 0); step();
    check("d4_sel1", obs_sel1, 0);

    // Frozen pipeline holds the load in stage 1
    op(1, 7, 1, LAT_LOAD, 0, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      op(1, 8, 1, LAT_ALU, 7, 1, 0, 0);
      ext_stall = 1'b1;
      step();
      check("frz_stall", obs_stall, 1);
    end
    op(1, 8, 1, LAT_ALU, 7, 1, 0, 0); step();
    check("frz_release_stall", obs_stall, 1);
    step();
    check("frz_after_stall", obs_stall, 0);
    check("frz_after_sel1", obs_sel1, 2);

    // Flush of the load as it moves to stage 2
    op(1, 7, 1, LAT_LOAD, 0, 0, 0, 0); step();
    op(1, 8, 1, LAT_ALU, 7, 1, 0, 0);
    flush_mask = 3'b010;
    step();
    flush_mask = '0;
    step();
    check("fl_stall", obs_stall, 0);
    check("fl_sel1", obs_sel1, 0);

    // Flush of stage 1 while frozen
    op(1, 7, 1, LAT_LOAD, 0, 0, 0, 0); step();
    op(1, 8, 1, LAT_ALU, 7, 1, 0, 0);
    ext_stall  = 1'b1;
    flush_mask = 3'b001;
    step();
    op(1, 8, 1, LAT_ALU, 7, 1, 0, 0); step();
    check("flf_stall", obs_stall, 0);
    check("flf_sel1", obs_sel1, 0);

    // Reset in the middle of a stall
    op(1, 7, 1, LAT_LOAD, 0, 0, 0, 0); step();
    op(1, 8, 1, LAT_ALU, 7, 1, 0, 0); step();
    check("rs_pre_stall", obs_stall, 1);
    rst = 1'b1; step();
    rst = 1'b0; step();
    check("rs_stall", obs_stall, 0);
    check("rs_cnt", obs_cnt, 0);

    // Random traffic on a small register window to provoke many matches
    for (int i = 0; i < 1500; i++) begin
      op($urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
         $urandom_range(1, DEPTH), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
         $urandom_range(0, 7), $urandom_range(0, 2) != 0);
      ext_stall  = ($urandom_range(0, 5) == 0);
      flush_mask = ($urandom_range(0, 7) == 0) ? DEPTH'($urandom_range(1, (1 << DEPTH) - 1)) : '0;
      flush_id   = ($urandom_range(0, 11) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    nop();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
